// File: rtl/switch_alloc_if.sv
// Request/grant/crossbar-select bundle between the route-computation units,
// the switch allocator and the crossbar of the 5-port router.
interface switch_alloc_if #(
  parameter int NPORT = 5,
  parameter int SELW  = 3
);
  logic [NPORT-1:0]       req_valid;
  logic [NPORT*NPORT-1:0] req_dir;
  logic [NPORT-1:0]       req_tail;
  logic [NPORT-1:0]       out_ready;
  logic [NPORT-1:0]       grant;
  logic [NPORT-1:0]       out_valid;
  logic [NPORT*SELW-1:0]  xbar_sel;

  modport master (
    output req_valid, req_dir, req_tail, out_ready,
    input  grant, out_valid, xbar_sel
  );

  modport slave (
    input  req_valid, req_dir, req_tail, out_ready,
    output grant, out_valid, xbar_sel
  );
endinterface

// File: rtl/switch_alloc.sv
// Per-output wormhole switch allocator: each output locks one input until its tail flit transfers.
// SWITCH_ALLOC_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
//
// state  | meaning
// IDLE   | output free; arbitrate among requesting inputs, xbar_sel = none
// LOCKED | output owned by owner_q; flits transfer on valid & ready until the tail
module switch_alloc #(
  parameter int NPORT = 5,
  parameter int SELW  = 3
) (
  input logic           sa_clk,
  input logic           rst,
  switch_alloc_if.slave sa
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q [NPORT];
  state_t          state_d [NPORT];
  logic [SELW-1:0] owner_q [NPORT];
  logic [SELW-1:0] owner_d [NPORT];
`ifdef SWITCH_ALLOC_RR_EN
  logic [SELW-1:0] ptr_q [NPORT];
  logic [SELW-1:0] ptr_d [NPORT];
`endif

  logic [NPORT-1:0] owned;
  logic [NPORT-1:0] cand [NPORT];

  // First set bit of c at or after start, wrapping modulo NPORT.
  function automatic logic [SELW-1:0] pick(input logic [NPORT-1:0] c,
                                            input logic [SELW-1:0]  start);
    logic [SELW-1:0] res;
    logic            hit;
    int              idx;
    res = '0;
    hit = 1'b0;
    for (int off = 0; off < NPORT; off++) begin
      idx = int'(start) + off;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!hit && c[idx]) begin
        hit = 1'b1;
        res = SELW'(idx);
      end
    end
    return res;
  endfunction

  always_ff @(posedge sa_clk) begin
    if (rst) begin
      for (int k = 0; k < NPORT; k++) begin
        state_q[k] <= IDLE;
        owner_q[k] <= '0;
`ifdef SWITCH_ALLOC_RR_EN
        ptr_q[k]   <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        state_q[k] <= state_d[k];
        owner_q[k] <= owner_d[k];
`ifdef SWITCH_ALLOC_RR_EN
        ptr_q[k]   <= ptr_d[k];
`endif
      end
    end
  end

  always_comb begin
    owned        = '0;
    sa.grant     = '0;
    sa.out_valid = '0;
    sa.xbar_sel  = '1;
    for (int k = 0; k < NPORT; k++) begin
      state_d[k] = state_q[k];
      owner_d[k] = owner_q[k];
      cand[k]    = '0;
`ifdef SWITCH_ALLOC_RR_EN
      ptr_d[k]   = ptr_q[k];
`endif
    end

    // An input held by any output may not compete elsewhere.
    for (int k = 0; k < NPORT; k++) begin
      if (state_q[k] == LOCKED) owned[owner_q[k]] = 1'b1;
    end

    for (int k = 0; k < NPORT; k++) begin
      for (int i = 0; i < NPORT; i++) begin
        cand[k][i] = sa.req_valid[i] & sa.req_dir[NPORT*i + k] & ~owned[i];
      end
    end

    for (int k = 0; k < NPORT; k++) begin
      case (state_q[k])
        IDLE: begin
          if (|cand[k]) begin
            state_d[k] = LOCKED;
`ifdef SWITCH_ALLOC_RR_EN
            owner_d[k] = pick(cand[k], ptr_q[k]);
`else
            owner_d[k] = pick(cand[k], '0);
`endif
          end
        end
        LOCKED: begin
          sa.xbar_sel[k*SELW +: SELW] = owner_q[k];
          if (sa.req_valid[owner_q[k]] && sa.out_ready[k]) begin
            sa.grant[owner_q[k]] = 1'b1;
            sa.out_valid[k]      = 1'b1;
            if (sa.req_tail[owner_q[k]]) begin
              state_d[k] = IDLE;
`ifdef SWITCH_ALLOC_RR_EN
              ptr_d[k] = (owner_q[k] == SELW'(NPORT-1)) ? '0 : owner_q[k] + 1'b1;
`endif
            end
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_alloc.sv
// Directed-vector bench for switch_alloc: the driver queues hand-computed expected outputs,
// a monitor pops and compares them each cycle on the falling edge.
module tb_switch_alloc;
  localparam int NPORT = 5;
  localparam int SELW  = 3;
  localparam logic [14:0] IDL = 15'h7FFF;
  localparam logic [4:0]  ALL = 5'h1F;

  typedef struct {
    bit          chk;
    logic [4:0]  g;
    logic [4:0]  v;
    logic [14:0] s;
    int          idx;
  } exp_t;

  logic sa_clk = 1'b0;
  logic rst    = 1'b1;
  exp_t exp_q[$];
  bit   done   = 1'b0;
  int   vec_id = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  switch_alloc_if #(.NPORT(NPORT), .SELW(SELW)) sa_if ();

  switch_alloc #(.NPORT(NPORT), .SELW(SELW)) dut (
    .sa_clk (sa_clk),
    .rst    (rst),
    .sa     (sa_if.slave)
  );

  always #5 sa_clk = ~sa_clk;

  function automatic logic [24:0] dd(input int i, input int k);
    logic [24:0] one;
    one = 25'd1;
    return one << (5*i + k);
  endfunction

  function automatic logic [14:0] sf(input logic [14:0] base, input int k, input int i);
    logic [14:0] r;
    r = base;
    r[3*k +: 3] = 3'(i);
    return r;
  endfunction

  task automatic step(input logic r, input logic [4:0] rv, input logic [24:0] dir,
                      input logic [4:0] tl, input logic [4:0] rdy, input bit chk,
                      input logic [4:0] eg, input logic [4:0] ev, input logic [14:0] es);
    exp_t e;
    @(posedge sa_clk);
    #1;
    rst               = r;
    sa_if.req_valid   = rv;
    sa_if.req_dir     = dir;
    sa_if.req_tail    = tl;
    sa_if.out_ready   = rdy;
    e.chk = chk; e.g = eg; e.v = ev; e.s = es; e.idx = vec_id;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Illegal multi-hot directions must never appear in the stimulus.
  always @(negedge sa_clk) begin
    if (!rst) begin
      for (int i = 0; i < NPORT; i++) begin
        if (sa_if.req_valid[i])
          assert ($onehot0(sa_if.req_dir[5*i +: 5]))
            else $error("illegal multi-hot req_dir on input %0d", i);
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   finished;
    finished = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge sa_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          n_checks++;
          if (sa_if.grant !== e.g) begin
            n_fail++;
            $display("FAIL grant vec %0d: got %b want %b", e.idx, sa_if.grant, e.g);
          end
          n_checks++;
          if (sa_if.out_valid !== e.v) begin
            n_fail++;
            $display("FAIL out_valid vec %0d: got %b want %b", e.idx, sa_if.out_valid, e.v);
          end
          n_checks++;
          if (sa_if.xbar_sel !== e.s) begin
            n_fail++;
            $display("FAIL xbar_sel vec %0d: got %h want %h", e.idx, sa_if.xbar_sel, e.s);
          end
        end
      end
      if (done && exp_q.size() == 0) finished = 1'b1;
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: monitor cycle budget expired with %0d vectors pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Driver
  initial begin
    int rr_order[6];
    int w;
    logic [24:0] d3;
    rr_order = '{0, 1, 3, 0, 1, 3};
    sa_if.req_valid = '0;
    sa_if.req_dir   = '0;
    sa_if.req_tail  = '0;
    sa_if.out_ready = ALL;

    // reset then idle
    step(1, 0, 0, 0, ALL, 0, 0, 0, IDL);
    step(1, 0, 0, 0, ALL, 1, 0, 0, IDL);
    step(0, 0, 0, 0, ALL, 1, 0, 0, IDL);
    step(0, 0, 0, 0, ALL, 1, 0, 0, IDL);

    // single flit N -> E
    step(0, 5'b00010, dd(1,2), 5'b00010, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b00010, dd(1,2), 5'b00010, ALL, 1, 5'b00010, 5'b00100, sf(IDL,2,1));
    step(0, 5'b00000, 0,       5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);

    // wormhole lock: W 3-flit to L with a bubble, S single flit waits
    step(0, 5'b01001, dd(0,4) | dd(3,4), 5'b01000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b01001, dd(0,4) | dd(3,4), 5'b01000, ALL, 1, 5'b00001, 5'b10000, sf(IDL,4,0));
    step(0, 5'b01000, dd(3,4),           5'b01000, ALL, 1, 5'b00000, 5'b00000, sf(IDL,4,0));
    step(0, 5'b01001, dd(3,4),           5'b01000, ALL, 1, 5'b00001, 5'b10000, sf(IDL,4,0));
    step(0, 5'b01001, dd(3,4),           5'b01001, ALL, 1, 5'b00001, 5'b10000, sf(IDL,4,0));
    step(0, 5'b01000, dd(3,4),           5'b01000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b01000, dd(3,4),           5'b01000, ALL, 1, 5'b01000, 5'b10000, sf(IDL,4,3));
    step(0, 5'b00000, 0,                 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);

    // backpressure on E during a W 3-flit packet
    step(0, 5'b00001, dd(0,2), 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b00001, dd(0,2), 5'b00000, ALL, 1, 5'b00001, 5'b00100, sf(IDL,2,0));
    for (int c = 0; c < 4; c++)
      step(0, 5'b00001, 0, 5'b00000, 5'b11011, 1, 5'b00000, 5'b00000, sf(IDL,2,0));
    step(0, 5'b00001, 0, 5'b00000, ALL, 1, 5'b00001, 5'b00100, sf(IDL,2,0));
    step(0, 5'b00001, 0, 5'b00001, ALL, 1, 5'b00001, 5'b00100, sf(IDL,2,0));
    step(0, 5'b00000, 0, 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);

    // fairness: inputs 0,1,3 stream single flits to L
    d3 = dd(0,4) | dd(1,4) | dd(3,4);
    step(0, 5'b01011, d3, 5'b01011, ALL, 1, 5'b00000, 5'b00000, IDL);
    for (int p = 0; p < 6; p++) begin
`ifdef SWITCH_ALLOC_RR_EN
      w = rr_order[p];
`else
      w = 0;
`endif
      step(0, 5'b01011, d3, 5'b01011, ALL, 1, 5'(1 << w), 5'b10000, sf(IDL,4,w));
      if (p < 5) step(0, 5'b01011, d3, 5'b01011, ALL, 1, 5'b00000, 5'b00000, IDL);
    end
    step(0, 5'b00000, 0, 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);

    // concurrent transfers on two outputs
    step(0, 5'b10100, dd(2,0) | dd(4,1), 5'b10100, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b10100, dd(2,0) | dd(4,1), 5'b10100, ALL, 1, 5'b10100, 5'b00011,
         sf(sf(IDL,0,2),1,4));
    step(0, 5'b00000, 0, 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);

    // reset mid-packet: N 4-flit to S, reset after the 2nd flit
    step(0, 5'b00010, dd(1,3), 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b00010, dd(1,3), 5'b00000, ALL, 1, 5'b00010, 5'b01000, sf(IDL,3,1));
    step(0, 5'b00010, dd(1,3), 5'b00000, ALL, 1, 5'b00010, 5'b01000, sf(IDL,3,1));
    step(1, 5'b00010, 0,       5'b00000, ALL, 0, 5'b00000, 5'b00000, IDL);
    step(0, 5'b11010, dd(3,4) | dd(4,4), 5'b11000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b11010, dd(3,4) | dd(4,4), 5'b11000, ALL, 1, 5'b01000, 5'b10000, sf(IDL,4,3));
    step(0, 5'b10000, dd(4,4),           5'b10000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b10000, dd(4,4),           5'b10000, ALL, 1, 5'b10000, 5'b10000, sf(IDL,4,4));
    step(0, 5'b00000, 0,                 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);
    step(0, 5'b00000, 0,                 5'b00000, ALL, 1, 5'b00000, 5'b00000, IDL);
    done = 1'b1;
  end
endmodule

// File: doc/switch_alloc.md
# switch_alloc

Per-output wormhole switch allocator for the 5-port router. It sits between the five route-computation units (one per input port: W, N, E, S, L) and the crossbar. It arbitrates each output port among the inputs whose computed one-hot direction targets it, and locks the winner until that packet's tail flit has transferred. It drives per-input grants (FIFO pop) and per-output crossbar selects.

## Interface
Parameters:
- NPORT, 5, number of ports; port index order 0=W, 1=N, 2=E, 3=S, 4=L (inputs and outputs alike)
- SELW, 3, width of one crossbar select field

Ports:
- sa_clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NPORT  input i holds a flit awaiting switch traversal
- req_dir  input  NPORT*5  bits [5i+4:5i] are input i's one-hot output direction (bit k = output port k)
- req_tail  input  NPORT  flit at input i is a packet's last flit (single-flit packets assert it on the head)
- out_ready  input  NPORT  output port k can accept a flit this cycle
- grant  output  NPORT  input i's flit transfers this cycle (pop)
- out_valid  output  NPORT  output port k carries a transferred flit this cycle
- xbar_sel  output  NPORT*SELW  bits [3k+2:3k] = input index driving output k; 3'b111 = none

## Operation
- Each output k has a 2-state FSM plus a 3-bit owner register and a 3-bit priority pointer.
  - IDLE: xbar_sel[k]=3'b111, out_valid[k]=0. Candidates are inputs i with req_valid[i] & req_dir[5i+k]. If any candidate exists, pick the winner per the Configuration policy, load owner, and go to LOCKED next cycle.
  - LOCKED: xbar_sel[k]=owner. Transfer when req_valid[owner] & out_ready[k]. A transfer asserts grant[owner] and out_valid[k] combinationally in the same cycle. A transfer with req_tail[owner]=1 returns the FSM to IDLE next cycle and sets the pointer to (owner+1) mod 5.
- In LOCKED, req_valid[owner]=0 (bubble mid-packet) keeps the lock with no grant. The lock is held indefinitely until the tail transfers.
- The requester's req_dir is sampled only in IDLE. Body flits do not need a valid req_dir.
- req_dir must be one-hot or zero. If it has multiple bits set, the input requests every flagged output. Such input is illegal, and the bench flags it with an assertion.
- Only one output may lock a given input: an input already owned by an output is excluded from candidacy at all other outputs.
- Outputs arbitrate independently and concurrently. Up to 5 transfers can occur per cycle.

## Timing
- Reset (rst=1 at an edge): all FSMs go to IDLE, pointers to 0, owners to 0. Next cycle grant=0, out_valid=0, xbar_sel=all 1s. Reset mid-packet drops the lock; no partial-packet recovery.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle n gives the earliest grant at cycle n+1.
- A single-flit packet occupies its output for 2 cycles. An N-flit packet under continuous valid/ready takes N+1 cycles.
- A tail transfer and a new request in the same cycle: release happens first, and the new arbitration occurs in the following IDLE cycle, so there is always one idle cycle between packets on an output.
- grant and out_valid are combinational from req_valid/out_ready and the registered state. There is no combinational path from req_dir to any output.

## Configuration
- SWITCH_ALLOC_RR_EN defined: round-robin. The winner is the first candidate at or after the pointer, scanning upward mod 5. The pointer updates only on tail transfer.
- SWITCH_ALLOC_RR_EN undefined: fixed priority, lowest index wins (W highest). Pointer registers are not built and the pointer stays 0.

## Test plan
- Reset then idle: rst held 2 cycles, all req_valid=0 → grant=0, out_valid=0, xbar_sel=15'h7FFF for every cycle.
- Single flit: input N (1) requests E (req_dir[9:5]=5'b00100, tail=1), out_ready=all 1 → cycle+1: grant=5'b00010, out_valid=5'b00100, xbar_sel[8:6]=3'd1; cycle+2: output E IDLE, sel 3'b111.
- Wormhole lock: input W sends a 3-flit packet to L while input S requests L, with a bubble on W after the head → grant to W only for all 3 flits. S is granted only after W's tail plus one idle cycle.
- Backpressure: out_ready[2]=0 for 4 cycles during a locked packet → no grant/out_valid on that output, lock kept; transfer resumes the cycle out_ready returns.
- Fairness (RR_EN): inputs 0,1,3 continuously send single-flit packets to output 4 → grant order 0,1,3,0,1,3. Without the macro: 0,0,0….
- Reset mid-packet: rst asserted after the 2nd of 4 flits → next cycle all outputs IDLE and sel all 1s; a fresh request rearbitrates from pointer 0.
